// File: rtl/divmod_pkg.sv
// Shared types and limits for the iterative divide/modulo engine.
package divmod_pkg;
  localparam int STATE_W   = 2;
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;
endpackage

// File: rtl/divmod_if.sv
// Request/result bundle of the divide/modulo engine.
interface divmod_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;
  logic             overflow;

  modport master (
    output start, A, B,
    input  busy, done, Q, R, div_by_zero, overflow
  );

  modport slave (
    input  start, A, B,
    output busy, done, Q, R, div_by_zero, overflow
  );
endinterface

// File: rtl/seq_divmod.sv
// Restoring divider: one quotient bit per clock, quotient and
// remainder together, with divide-by-zero and overflow flags.
module seq_divmod
  import divmod_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b1
) (
  input  logic     clk,
  input  logic     rst_n,
  divmod_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("seq_divmod: WIDTH out of range");
  end

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic [WIDTH-1:0] q_r, r_r;
  logic             sign_a, sign_q;
  logic             dbz, ovf;
  logic             done_r, dbz_r, ovf_r;

  logic             accept, b_zero;
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   rem_sh, diff;

  // The done cycle still blocks start even though state is IDLE.
  assign accept = bus.start && (state == IDLE) && !done_r;
  assign b_zero = (bus.B == '0);
  assign a_neg  = SIGNED && bus.A[WIDTH-1];
  assign b_neg  = SIGNED && bus.B[WIDTH-1];
  assign a_mag  = a_neg ? -bus.A : bus.A;
  assign b_mag  = b_neg ? -bus.B : bus.B;
  assign rem_sh = {rem, quo[WIDTH-1]};
  assign diff   = rem_sh - {1'b0, dvs};

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (accept) state_nx = b_zero ? FIX : CALC;
      CALC:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= '0;
      rem    <= '0;
      quo    <= '0;
      dvs    <= '0;
      sign_a <= 1'b0;
      sign_q <= 1'b0;
      dbz    <= 1'b0;
      ovf    <= 1'b0;
      done_r <= 1'b0;
      dbz_r  <= 1'b0;
      ovf_r  <= 1'b0;
      q_r    <= '0;
      r_r    <= '0;
    end else begin
      done_r <= 1'b0;
      unique case (state)
        IDLE: if (accept) begin
          dbz    <= b_zero;
          ovf    <= SIGNED && (bus.A == MIN) && (bus.B == '1);
          sign_a <= a_neg;
          sign_q <= a_neg ^ b_neg;
          // On divide-by-zero quo just carries A through to R.
          quo    <= b_zero ? bus.A : a_mag;
          dvs    <= b_mag;
          rem    <= '0;
          cnt    <= CW'(WIDTH-1);
        end
        CALC: begin
          rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
          quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          done_r <= 1'b1;
          dbz_r  <= dbz;
          ovf_r  <= ovf;
          q_r    <= dbz ? '1 : (sign_q ? -quo : quo);
          r_r    <= dbz ? quo : (sign_a ? -rem : rem);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_r;
  assign bus.Q           = q_r;
  assign bus.R           = r_r;
  assign bus.div_by_zero = dbz_r;
  assign bus.overflow    = ovf_r;
endmodule

// File: tb/tb_seq_divmod.sv
// Scoreboard bench: signed and unsigned 8-bit dividers against a
// plain-arithmetic reference model.
module tb_seq_divmod;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dbz;
    logic         ovf;
    int           t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t qs[$];
  exp_t qu[$];

  divmod_if #(.WIDTH(W)) ifs();
  divmod_if #(.WIDTH(W)) ifu();

  seq_divmod #(.WIDTH(W), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(ifs)
  );
  seq_divmod #(.WIDTH(W), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst_n(rst_n), .bus(ifu)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input bit sg, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
    exp_t e;
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    e.q = '0; e.r = '0; e.dbz = 1'b0; e.ovf = 1'b0; e.t = 0;
    if (b == 0) begin
      e.q = '1; e.r = a; e.dbz = 1'b1;
    end else if (sg && a == 8'h80 && b == 8'hFF) begin
      e.q = 8'h80; e.r = '0; e.ovf = 1'b1;
    end else if (sg) begin
      e.q = sa / sb;
      e.r = sa % sb;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
    return e;
  endfunction

  task automatic mon(input bit sg, input logic busy,
                     input logic [W-1:0] q, input logic [W-1:0] r,
                     input logic dbz, input logic ovf, input logic pd);
    exp_t  e;
    string p;
    p = sg ? "s" : "u";
    if (sg ? (qs.size() == 0) : (qu.size() == 0)) begin
      chk({p, ".unexpected_done"}, 1, 0);
      return;
    end
    if (sg) e = qs.pop_front();
    else    e = qu.pop_front();
    chk({p, ".Q"}, q, e.q);
    chk({p, ".R"}, r, e.r);
    chk({p, ".dbz"}, dbz, e.dbz);
    chk({p, ".ovf"}, ovf, e.ovf);
    chk({p, ".done_cycle"}, cyc, e.t);
    chk({p, ".busy_at_done"}, busy, 0);
    chk({p, ".done_twice"}, pd, 0);
  endtask

  logic pd_s = 1'b0;
  logic pd_u = 1'b0;

  always @(negedge clk) begin
    if (ifs.done)
      mon(1'b1, ifs.busy, ifs.Q, ifs.R, ifs.div_by_zero, ifs.overflow, pd_s);
    pd_s = ifs.done;
  end

  always @(negedge clk) begin
    if (ifu.done)
      mon(1'b0, ifu.busy, ifu.Q, ifu.R, ifu.div_by_zero, ifu.overflow, pd_u);
    pd_u = ifu.done;
  end

  task automatic drive(input bit sg, input logic st,
                       input logic [W-1:0] a, input logic [W-1:0] b);
    if (sg) begin ifs.start = st; ifs.A = a; ifs.B = b; end
    else    begin ifu.start = st; ifu.A = a; ifu.B = b; end
  endtask

  function automatic logic busy_of(input bit sg);
    return sg ? ifs.busy : ifu.busy;
  endfunction

  function automatic logic done_of(input bit sg);
    return sg ? ifs.done : ifu.done;
  endfunction

  task automatic wait_idle(input bit sg);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy_of(sg) || done_of(sg)) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("wait_idle_timeout", 1, 0);
  endtask

  // Returns at the negedge after the accepting edge.
  task automatic issue(input bit sg, input logic [W-1:0] a,
                       input logic [W-1:0] b);
    exp_t e;
    wait_idle(sg);
    drive(sg, 1'b1, a, b);
    @(posedge clk);
    #1;
    e = model(sg, a, b);
    e.t = cyc + ((b == 0) ? 1 : W + 1);
    if (sg) qs.push_back(e);
    else    qu.push_back(e);
    chk(sg ? "s.accept_busy" : "u.accept_busy", busy_of(sg), 1);
    @(negedge clk);
    drive(sg, 1'b0, a, b);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".s.busy"}, ifs.busy, 0);
    chk({tag, ".s.done"}, ifs.done, 0);
    chk({tag, ".s.Q"}, ifs.Q, 0);
    chk({tag, ".s.R"}, ifs.R, 0);
    chk({tag, ".s.flags"}, {ifs.div_by_zero, ifs.overflow}, 0);
    chk({tag, ".u.busy"}, ifu.busy, 0);
    chk({tag, ".u.Q"}, ifu.Q, 0);
  endtask

  initial begin
    int n;
    logic [W-1:0] a, b;
    bit sg;

    drive(1'b1, 1'b0, '0, '0);
    drive(1'b0, 1'b0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_state("por");
    @(negedge clk);
    rst_n = 1'b1;

    // -7 / 2 with busy-length measurement
    issue(1'b1, 8'(-7), 8'd2);
    n = 1;
    while (n < 100) begin
      @(negedge clk);
      if (!ifs.busy) break;
      n++;
    end
    chk("s.busy_cycles", n, 9);

    issue(1'b1, 8'd7, 8'(-2));
    issue(1'b1, 8'h80, 8'hFF);
    issue(1'b1, 8'd100, 8'd0);
    issue(1'b1, 8'd9, 8'd3);
    issue(1'b0, 8'd200, 8'd7);
    issue(1'b0, 8'd255, 8'd1);
    issue(1'b0, 8'd0, 8'd0);

    // start while busy is ignored
    issue(1'b0, 8'd50, 8'd5);
    @(negedge clk);
    drive(1'b0, 1'b1, 8'd1, 8'd1);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd1, 8'd1);

    // start during the done cycle is ignored
    issue(1'b0, 8'd20, 8'd3);
    n = 0;
    while (n < 100) begin
      @(negedge clk);
      if (ifu.done) break;
      n++;
    end
    chk("u.saw_done", ifu.done, 1);
    drive(1'b0, 1'b1, 8'd5, 8'd1);
    @(posedge clk);
    #1;
    chk("u.start_in_done_ignored", ifu.busy, 0);
    @(negedge clk);
    drive(1'b0, 1'b0, 8'd5, 8'd1);
    issue(1'b0, 8'd7, 8'd7);

    // reset in the middle of an operation
    issue(1'b1, 8'(-7), 8'd2);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_state("mid");
    qs.delete();
    qu.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    issue(1'b1, 8'(-7), 8'd2);

    for (int i = 0; i < 60; i++) begin
      sg = ($urandom_range(0, 1) == 1);
      a  = 8'($urandom);
      b  = 8'($urandom);
      if ($urandom_range(0, 7) == 0) b = '0;
      if ($urandom_range(0, 9) == 0) begin a = 8'h80; b = 8'hFF; end
      issue(sg, a, b);
    end

    n = 0;
    while ((qs.size() != 0 || qu.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
